// File: rtl/ula_pkg.sv
// Shared constants for the ALU operand-entry front end: sequence states,
// ALU opcode encoding and the default key debounce window.
package ula_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  // 1 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one active-low pushbutton; emits a one-cycle
// press pulse when the accepted level falls.
module key_debouncer
  import ula_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mismatch;
  logic             w_cnt_done;

  assign w_mismatch = (r_sync2 != r_level);
  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press      = r_press;

  // Level is accepted only after a mismatch survives the full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_cnt_done) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_level & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ula_operand_sequencer.sv
// Operand-entry sequencer for the 4-bit ALU: steps through A, B, opcode/cin
// on debounced key presses and holds the ALU inputs in registers.
module ula_operand_sequencer
  import ula_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_data,
  input  logic [2:0] sw_op,
  input  logic       sw_cin,
  input  logic       key_next_n,
  input  logic       key_clear_n,
  input  logic       alu_err,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       cin_out,
  output logic [2:0] op_out,
  output logic       valid,
  output logic       err_flag,
  output logic [1:0] step
);

  logic       w_next_press;
  logic       w_clear_press;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_a, w_a_nxt;
  logic [3:0] r_b, w_b_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic       r_cin, w_cin_nxt;
  logic       r_err, w_err_nxt;
  logic       r_valid;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_next_db (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (w_next_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear_db (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clear_n),
    .press (w_clear_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cin   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_cin   <= w_cin_nxt;
      r_err   <= w_err_nxt;
      r_valid <= (w_state_nxt == RUN);
    end
  end

  // Clear overrides everything; an error seen in RUN outranks the exit clear
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_cin_nxt   = r_cin;
    w_err_nxt   = r_err;
    if (w_clear_press) begin
      w_state_nxt = LOAD_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_op_nxt    = '0;
      w_cin_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      if (w_next_press) begin
        case (r_state)
          LOAD_A: begin
            w_a_nxt     = sw_data;
            w_state_nxt = LOAD_B;
          end
          LOAD_B: begin
            w_b_nxt     = sw_data;
            w_state_nxt = LOAD_OP;
          end
          LOAD_OP: begin
            w_op_nxt    = sw_op;
            w_cin_nxt   = sw_cin;
            w_state_nxt = RUN;
          end
          RUN: begin
            w_err_nxt   = 1'b0;
            w_state_nxt = LOAD_A;
          end
          default: w_state_nxt = LOAD_A;
        endcase
      end
      if ((r_state == RUN) && alu_err) begin
        w_err_nxt = 1'b1;
      end
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign cin_out  = r_cin;
  assign op_out   = r_op;
  assign valid    = r_valid;
  assign err_flag = r_err;
  assign step     = 2'(r_state);

endmodule
